// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit: PC + FETCH_DEPTH-entry instruction queue, conditional
// branch resolution, 2-bit BHT and redirect on mispredict or external flush.
// Optional macro FETCH_BTB_EN adds a direct-mapped BTB for dynamic prediction.
// Without FETCH_BTB_EN, prediction is static not-taken.
module fetch_branch_unit #(
  parameter int                WORD_W      = 32,
  parameter int                FETCH_DEPTH = 4,
  parameter int                BHT_ENTRIES = 64,
  parameter int                BTB_ENTRIES = 16,
  parameter logic [WORD_W-1:0] RESET_PC    = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              stall,
  input  logic              flush,
  input  logic [WORD_W-1:0] flush_pc,
  input  logic              dispatch_free,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc,
  output logic              predicted_outcome,
  output logic              instr_valid,
  input  logic              branch,
  input  logic [1:0]        branch_type,
  input  logic [WORD_W-1:0] reg_a,
  input  logic [WORD_W-1:0] reg_b,
  input  logic [WORD_W-1:0] current_pc,
  input  logic [WORD_W-1:0] imm,
  input  logic              branch_pred,
  output logic              mispredict
);
  localparam int PTR_W  = $clog2(FETCH_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BHT_IW = $clog2(BHT_ENTRIES);

  // Table sizes are assumed to be powers of two by the index slicing below.
  if ((FETCH_DEPTH < 2) || ((FETCH_DEPTH & (FETCH_DEPTH - 1)) != 0) ||
      ((BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0) ||
      ((BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0)) begin : g_bad_cfg
    $error("fetch_branch_unit: FETCH_DEPTH/BHT_ENTRIES/BTB_ENTRIES must be powers of 2");
  end

  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_q_instr [FETCH_DEPTH];
  logic [WORD_W-1:0] r_q_pc    [FETCH_DEPTH];
  logic              r_q_pred  [FETCH_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [1:0]        r_bht     [BHT_ENTRIES];
  logic              r_mispredict;

  logic              w_full, w_valid, w_push, w_pop, w_redirect;
  logic              w_taken, w_miss, w_pred;
  logic [WORD_W-1:0] w_target, w_correct_pc, w_pred_tgt;
  logic [BHT_IW-1:0] w_bht_widx;

  assign w_full      = (r_count == CNT_W'(FETCH_DEPTH));
  assign w_valid     = (r_count != '0);
  assign w_redirect  = flush || w_miss;
  assign w_push      = ihit && !stall && !w_full && !w_redirect;
  assign w_pop       = dispatch_free && w_valid && !w_redirect;

  assign imemREN     = !RST && !w_full;
  assign imemaddr    = r_pc;
  assign instr_valid = w_valid;
  // Empty queue shows zeros rather than stale storage.
  assign instr             = w_valid ? r_q_instr[r_rptr] : '0;
  assign pc                = w_valid ? r_q_pc[r_rptr]    : '0;
  assign predicted_outcome = w_valid && r_q_pred[r_rptr];
  assign mispredict        = r_mispredict;

  // Branch compare, target and the PC fetch must resume from.
  always_comb begin
    w_taken = 1'b0;
    unique case (branch_type)
      2'b00: w_taken = (reg_a == reg_b);
      2'b01: w_taken = (reg_a != reg_b);
      2'b10: w_taken = ($signed(reg_a) <  $signed(reg_b));
      2'b11: w_taken = ($signed(reg_a) >= $signed(reg_b));
    endcase
    w_target     = current_pc + imm;
    w_correct_pc = w_taken ? w_target : current_pc + WORD_W'(4);
    w_miss       = branch && (w_taken != branch_pred);
  end

  assign w_bht_widx = current_pc[BHT_IW+1:2];

`ifdef FETCH_BTB_EN
  localparam int BTB_IW = $clog2(BTB_ENTRIES);
  localparam int TAG_W  = WORD_W - BTB_IW - 2;

  logic              r_btb_vld [BTB_ENTRIES];
  logic [TAG_W-1:0]  r_btb_tag [BTB_ENTRIES];
  logic [WORD_W-1:0] r_btb_tgt [BTB_ENTRIES];
  logic [BTB_IW-1:0] w_btb_ridx, w_btb_widx;
  logic              w_btb_hit;

  assign w_btb_ridx = r_pc[BTB_IW+1:2];
  assign w_btb_widx = current_pc[BTB_IW+1:2];
  assign w_btb_hit  = r_btb_vld[w_btb_ridx] && (r_btb_tag[w_btb_ridx] == r_pc[WORD_W-1:BTB_IW+2]);
  assign w_pred     = w_btb_hit && r_bht[r_pc[BHT_IW+1:2]][1];
  assign w_pred_tgt = r_btb_tgt[w_btb_ridx];

  // BTB valid bits; set on every taken branch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) r_btb_vld[i] <= 1'b0;
    end else if (branch && w_taken) begin
      r_btb_vld[w_btb_widx] <= 1'b1;
    end
  end

  // BTB tag/target payload, qualified by the valid bits.
  always_ff @(posedge CLK) begin
    if (branch && w_taken) begin
      r_btb_tag[w_btb_widx] <= current_pc[WORD_W-1:BTB_IW+2];
      r_btb_tgt[w_btb_widx] <= w_target;
    end
  end
`else
  assign w_pred     = 1'b0;
  assign w_pred_tgt = '0;
`endif

  // PC: redirect wins, otherwise advance on each accepted fetch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             r_pc <= RESET_PC;
    else if (w_redirect) r_pc <= flush ? flush_pc : w_correct_pc;
    else if (w_push)     r_pc <= w_pred ? w_pred_tgt : r_pc + WORD_W'(4);
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST || w_redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue payload; read side is gated by occupancy so no reset is needed.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_q_instr[r_wptr] <= imemload;
      r_q_pc[r_wptr]    <= r_pc;
      r_q_pred[r_wptr]  <= w_pred;
    end
  end

  // 2-bit saturating BHT, trained by every resolving branch (even under flush).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
    end else if (branch) begin
      if (w_taken && r_bht[w_bht_widx] != 2'b11)
        r_bht[w_bht_widx] <= r_bht[w_bht_widx] + 2'd1;
      else if (!w_taken && r_bht[w_bht_widx] != 2'b00)
        r_bht[w_bht_widx] <= r_bht[w_bht_widx] - 2'd1;
    end
  end

  // One-cycle mispredict pulse; a coincident flush masks it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_mispredict <= 1'b0;
    else     r_mispredict <= w_miss && !flush;
  end
endmodule

// File: tb/tb_fetch_branch_unit.sv
// Scoreboard bench for fetch_branch_unit: fetched entries are queued when the
// bench predicts a push and compared when the DUT presents them at the head.
module tb_fetch_branch_unit;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        ihit = 1'b0, stall = 1'b0, flush = 1'b0, dispatch_free = 1'b0;
  logic [31:0] flush_pc = '0, imemload, imemaddr, instr, pc;
  logic        imemREN, predicted_outcome, instr_valid, mispredict;
  logic        branch = 1'b0, branch_pred = 1'b0;
  logic [1:0]  branch_type = 2'b00;
  logic [31:0] reg_a = '0, reg_b = '0, current_pc = '0, imm = '0;

  int n_chk = 0, n_fail = 0;

  typedef struct { logic [31:0] instr; logic [31:0] pc; logic pred; } ent_t;
  ent_t        sb[$];
  logic [31:0] m_pc = '0;
  logic        m_misp = 1'b0;
  logic [1:0]  m_bht [64];
  logic        m_btb_v [16];
  logic [25:0] m_btb_tag [16];
  logic [31:0] m_btb_t [16];

  fetch_branch_unit dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
    .imemaddr(imemaddr), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .dispatch_free(dispatch_free), .instr(instr), .pc(pc),
    .predicted_outcome(predicted_outcome), .instr_valid(instr_valid),
    .branch(branch), .branch_type(branch_type), .reg_a(reg_a), .reg_b(reg_b),
    .current_pc(current_pc), .imm(imm), .branch_pred(branch_pred),
    .mispredict(mispredict));

  always #5 CLK = ~CLK;

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction
  assign imemload = fetch_word(imemaddr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: inputs already set by the caller just after a falling edge.
  task automatic step(input bit ih, input bit st, input bit df);
    logic        taken, miss, redir, full, push, pop, pred;
    logic [31:0] tgt, ptgt;
    ent_t        e;
    ihit = ih; stall = st; dispatch_free = df;
    #1;
    unique case (branch_type)
      2'b00: taken = reg_a == reg_b;
      2'b01: taken = reg_a != reg_b;
      2'b10: taken = $signed(reg_a) < $signed(reg_b);
      default: taken = $signed(reg_a) >= $signed(reg_b);
    endcase
    tgt   = current_pc + imm;
    miss  = branch && (taken != branch_pred);
    redir = flush || miss;
    full  = sb.size() == DEPTH;
    push  = ih && !st && !full && !redir;
    pop   = df && sb.size() > 0 && !redir;
    pred  = 1'b0;
    ptgt  = m_pc + 4;
`ifdef FETCH_BTB_EN
    if (m_btb_v[m_pc[5:2]] && m_btb_tag[m_pc[5:2]] == m_pc[31:6] && m_bht[m_pc[7:2]][1]) begin
      pred = 1'b1;
      ptgt = m_btb_t[m_pc[5:2]];
    end
`endif
    chk("imemREN", imemREN, !full);
    chk("instr_valid", instr_valid, sb.size() > 0);
    if (sb.size() > 0) begin
      chk("head_instr", instr, sb[0].instr);
      chk("head_pc", pc, sb[0].pc);
      chk("head_pred", predicted_outcome, sb[0].pred);
    end
    @(posedge CLK);
    if (branch) begin
      if (taken && m_bht[current_pc[7:2]] != 2'b11) m_bht[current_pc[7:2]] += 2'd1;
      else if (!taken && m_bht[current_pc[7:2]] != 2'b00) m_bht[current_pc[7:2]] -= 2'd1;
      if (taken) begin
        m_btb_v[current_pc[5:2]]   = 1'b1;
        m_btb_tag[current_pc[5:2]] = current_pc[31:6];
        m_btb_t[current_pc[5:2]]   = tgt;
      end
    end
    m_misp = miss && !flush;
    if (redir) begin
      sb.delete();
      m_pc = flush ? flush_pc : (taken ? tgt : current_pc + 4);
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) begin
        e.instr = fetch_word(m_pc); e.pc = m_pc; e.pred = pred;
        sb.push_back(e);
        m_pc = pred ? ptgt : m_pc + 4;
      end
    end
    @(negedge CLK);
    branch = 1'b0; flush = 1'b0;
    chk("mispredict", mispredict, m_misp);
    chk("imemaddr", imemaddr, m_pc);
  endtask

  task automatic set_br(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] cpc, input logic [31:0] im, input logic bp);
    branch = 1'b1; branch_type = t; reg_a = a; reg_b = b;
    current_pc = cpc; imm = im; branch_pred = bp;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    for (int i = 0; i < 16; i++) begin m_btb_v[i] = 1'b0; m_btb_tag[i] = '0; m_btb_t[i] = '0; end

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_imemREN", imemREN, 0);
    chk("rst_imemaddr", imemaddr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_pred", predicted_outcome, 0);
    chk("rst_misp", mispredict, 0);
    chk("rst_bht", dut.r_bht[5], 2'b01);
    RST = 1'b0;

    // Fill: four pushes then hold full
    repeat (6) step(1, 0, 0);
    chk("t1_imemREN", imemREN, 0);
    chk("t1_valid", instr_valid, 1);
    chk("t1_headpc", pc, 0);
    chk("t1_addr", imemaddr, 32'h10);

    // Drain while fetching at full
    repeat (10) step(1, 0, 1);
    repeat (3) step(1, 1, 1);

    // BEQ taken, predicted not-taken
    set_br(2'b00, 5, 5, 32'h10, 32'h20, 1'b0);
    step(1, 0, 1);
    chk("t3_misp", mispredict, 1);
    chk("t3_addr", imemaddr, 32'h30);
    chk("t3_valid", instr_valid, 0);
    step(1, 0, 0);
    chk("t3_pulse", mispredict, 0);

    // Signed compares and BHT saturation
    repeat (3) begin set_br(2'b10, 32'hFFFF_FFFF, 1, 32'h80, 32'h40, 1'b1); step(1, 0, 0); end
    chk("t4_bht_sat", dut.r_bht[32], 2'b11);
    set_br(2'b11, 32'hFFFF_FFFF, 1, 32'h84, 32'h40, 1'b0); step(1, 0, 1);
    chk("t4_bge_nt", mispredict, 0);
    chk("t4_bht_dec", dut.r_bht[33], 2'b00);
    set_br(2'b11, 32'hFFFF_FFFF, 1, 32'h84, 32'h40, 1'b1); step(1, 0, 1);
    chk("t4_bge_fix", imemaddr, 32'h88);
    set_br(2'b01, 3, 3, 32'h200, 32'h40, 1'b1); step(0, 0, 1);
    chk("t4_bne_fix", imemaddr, 32'h204);
    repeat (3) step(1, 0, 0);

    // Flush coinciding with a mispredict
    set_br(2'b00, 5, 5, 32'h10, 32'h20, 1'b0);
    flush = 1'b1; flush_pc = 32'h100;
    step(1, 0, 0);
    chk("t5_addr", imemaddr, 32'h100);
    chk("t5_misp", mispredict, 0);
    chk("t5_valid", instr_valid, 0);

`ifdef FETCH_BTB_EN
    // Loop branch at 0x40 trained taken twice, then predicted on fetch
    repeat (2) begin
      flush = 1'b1; flush_pc = 32'h40; step(0, 0, 1);
      set_br(2'b00, 1, 1, 32'h40, 32'hFFFF_FFE0, 1'b0); step(0, 0, 1);
    end
    flush = 1'b1; flush_pc = 32'h40; step(0, 0, 1);
    step(1, 0, 0);
    chk("t6_pred", predicted_outcome, 1);
    chk("t6_addr", imemaddr, 32'h20);
`endif

    // Random traffic with occasional branches and flushes
    for (int c = 0; c < 300; c++) begin
      logic [31:0] ops [4];
      ops[0] = 32'hFFFF_FFFF; ops[1] = 0; ops[2] = 1; ops[3] = 5;
      if ($urandom_range(0, 5) == 0)
        set_br(2'($urandom_range(0, 3)), ops[$urandom_range(0, 3)], ops[$urandom_range(0, 3)],
               32'($urandom_range(0, 63)) << 2, (32'($urandom_range(0, 15)) << 2) - 32'h20,
               1'($urandom_range(0, 1)));
      if ($urandom_range(0, 19) == 0) begin flush = 1'b1; flush_pc = 32'($urandom_range(0, 255)) << 2; end
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 64; i++) chk("bht_final", dut.r_bht[i], m_bht[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
